race_control: RTL and testbench

- Upstream control FSM for the car-racing datapath.
- Sequences reset, background draw, car draw, frame-paced wait, car erase, move, explosion and finish.
- Drives the datapath's one-hot command strobes and the VGA adapter's plot enable.
- Consumes the datapath's Done/status flags and the player's key inputs.

---
 rtl/race_pkg.sv | 50 +++++
 rtl/race_control_key_sync_edge.sv | 23 ++
 rtl/race_control.sv | 136 +++++++++++++
 tb/tb_race_control.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared types and constants for the car-racing controller and datapath.
package race_pkg;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_IDLE     = 4'd1,
      S_START    = 4'd2,
      S_DRAW_BG  = 4'd3,
      S_DRAW_CAR = 4'd4,
      S_CHECK    = 4'd5,
      S_WAIT     = 4'd6,
      S_ERASE    = 4'd7,
      S_MOVE     = 4'd8,
      S_EXPLODE  = 4'd9,
      S_DONE     = 4'd10
   } raceState_t;

   localparam int unsigned FRAME_CYCLES_DEFAULT = 833333;
   localparam int unsigned SPRITE_SIZE          = 32;
   localparam int unsigned SCREEN_W             = 320;
   localparam int unsigned SCREEN_H             = 240;

   typedef struct packed {
      logic setReset;
      logic startRace;
      logic drawBackground;
      logic drawCar;
      logic drawOverCar;
      logic moveCar;
      logic drawExplosion;
   } raceCmd_t;

   // Moore command decode; every state maps to at most one strobe.
   function automatic raceCmd_t decodeCmd(input raceState_t s);
      raceCmd_t c;
      c = '0;
      case (s)
         S_RESET:    c.setReset       = 1'b1;
         S_START:    c.startRace      = 1'b1;
         S_DRAW_BG:  c.drawBackground = 1'b1;
         S_DRAW_CAR: c.drawCar        = 1'b1;
         S_ERASE:    c.drawOverCar    = 1'b1;
         S_MOVE:     c.moveCar        = 1'b1;
         S_EXPLODE:  c.drawExplosion  = 1'b1;
         default:    c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/race_control_key_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by rising-edge detect.
// keyPulse is high for one Clock cycle, two to three cycles after the press.
module key_sync_edge (
   input  logic Clock,
   input  logic Resetn,
   input  logic keyRaw,
   output logic keyPulse
);

   // syncQ[0..1] are the metastability stages, syncQ[2] holds the previous level.
   logic [2:0] syncQ;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         syncQ <= '0;
      end else begin
         syncQ <= {syncQ[1:0], keyRaw};
      end
   end

   assign keyPulse = syncQ[1] & ~syncQ[2];

endmodule

// File: rtl/race_control.sv
// Sequencing FSM for the racing datapath: draw, frame-paced wait, erase/move, explode.
// Optional RACE_LAP_TIMER_EN adds lap_frames, a saturating count of elapsed frames.
module race_control
   import race_pkg::*;
#(
   parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
   parameter int unsigned TIMER_W      = 20
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        go_key,
   input  logic        moveForward,
   input  logic        moveRight,
   input  logic        moveLeft,
   input  logic        DoneDrawBackground,
   input  logic        DoneDrawCar,
   input  logic        DoneDrawOverCar,
   input  logic        DoneDrawExplosion,
   input  logic        FinishedRace,
   input  logic        HitWall,
   output logic        set_reset_signals,
   output logic        start_race,
   output logic        draw_background,
   output logic        draw_car,
   output logic        draw_over_car,
   output logic        move,
   output logic        draw_explosion,
   output logic        plot,
`ifdef RACE_LAP_TIMER_EN
   output logic [15:0] lap_frames,
`endif
   output logic [3:0]  state_dbg
);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_CYCLES - 1);

   raceState_t        stateQ, stateD;
   logic [TIMER_W-1:0] timerQ, timerD;
   logic              plotD;
   logic              goPulse;
   logic              anyKey;
   logic              frameEnd;
   raceCmd_t          cmd;

   key_sync_edge goSync (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .keyRaw   (go_key),
      .keyPulse (goPulse)
   );

   assign anyKey   = moveForward | moveRight | moveLeft;
   assign frameEnd = (stateQ == S_WAIT) && (timerQ == TIMER_LAST);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         stateQ <= S_RESET;
         timerQ <= '0;
         plot   <= 1'b0;
      end else begin
         stateQ <= stateD;
         timerQ <= timerD;
         plot   <= plotD;
      end
   end

   always_comb begin
      stateD = stateQ;
      timerD = timerQ;
      // plot tracks the datapath's registered pixel, so it is computed one cycle early.
      plotD  = ((stateQ == S_DRAW_BG)  && !DoneDrawBackground) ||
               ((stateQ == S_DRAW_CAR) && !DoneDrawCar)        ||
               ((stateQ == S_ERASE)    && !DoneDrawOverCar)    ||
               ((stateQ == S_EXPLODE)  && !DoneDrawExplosion);
      case (stateQ)
         S_RESET:    stateD = S_IDLE;
         S_IDLE:     if (goPulse) stateD = S_START;
         S_START:    stateD = S_DRAW_BG;
         S_DRAW_BG:  if (DoneDrawBackground) stateD = S_DRAW_CAR;
         S_DRAW_CAR: if (DoneDrawCar) stateD = S_CHECK;
         S_CHECK: begin
            if (HitWall) begin
               stateD = S_EXPLODE;
            end else if (FinishedRace) begin
               stateD = S_DONE;
            end else begin
               stateD = S_WAIT;
               timerD = '0;
            end
         end
         S_WAIT: begin
            if (frameEnd) begin
               // Idle frames restart the wait without touching the screen.
               timerD = '0;
               if (anyKey) stateD = S_ERASE;
            end else begin
               timerD = timerQ + 1'b1;
            end
         end
         S_ERASE:    if (DoneDrawOverCar) stateD = S_MOVE;
         S_MOVE:     stateD = S_DRAW_CAR;
         S_EXPLODE:  if (DoneDrawExplosion) stateD = S_DONE;
         S_DONE:     if (goPulse) stateD = S_RESET;
         default:    stateD = S_RESET;
      endcase
   end

   assign cmd               = decodeCmd(stateQ);
   assign set_reset_signals = cmd.setReset;
   assign start_race        = cmd.startRace;
   assign draw_background   = cmd.drawBackground;
   assign draw_car          = cmd.drawCar;
   assign draw_over_car     = cmd.drawOverCar;
   assign move              = cmd.moveCar;
   assign draw_explosion    = cmd.drawExplosion;
   assign state_dbg         = stateQ;

`ifdef RACE_LAP_TIMER_EN
   logic [15:0] lapQ;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         lapQ <= '0;
      end else if ((stateQ == S_RESET) || (stateQ == S_START)) begin
         lapQ <= '0;
      end else if (frameEnd && (lapQ != 16'hFFFF)) begin
         lapQ <= lapQ + 16'd1;
      end
   end

   assign lap_frames = lapQ;
`endif

   cmdOneHot: assert property (@(posedge Clock) disable iff (!Resetn) $onehot0(cmd));

endmodule

// File: tb/tb_race_control.sv
// Scoreboard bench for race_control: reference model predicts each cycle, monitor compares.
module tb_race_control;

   localparam int FC = 4;

   logic        Clock;
   logic        Resetn;
   logic        go_key;
   logic        moveForward, moveRight, moveLeft;
   logic        DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneDrawExplosion;
   logic        FinishedRace, HitWall;
   logic        set_reset_signals, start_race, draw_background, draw_car;
   logic        draw_over_car, move, draw_explosion, plot;
   logic [3:0]  state_dbg;
`ifdef RACE_LAP_TIMER_EN
   logic [15:0] lap_frames;
`endif

   race_control #(.FRAME_CYCLES(FC), .TIMER_W(20)) dut (
      .Clock              (Clock),
      .Resetn             (Resetn),
      .go_key             (go_key),
      .moveForward        (moveForward),
      .moveRight          (moveRight),
      .moveLeft           (moveLeft),
      .DoneDrawBackground (DoneDrawBackground),
      .DoneDrawCar        (DoneDrawCar),
      .DoneDrawOverCar    (DoneDrawOverCar),
      .DoneDrawExplosion  (DoneDrawExplosion),
      .FinishedRace       (FinishedRace),
      .HitWall            (HitWall),
      .set_reset_signals  (set_reset_signals),
      .start_race         (start_race),
      .draw_background    (draw_background),
      .draw_car           (draw_car),
      .draw_over_car      (draw_over_car),
      .move               (move),
      .draw_explosion     (draw_explosion),
      .plot               (plot),
`ifdef RACE_LAP_TIMER_EN
      .lap_frames         (lap_frames),
`endif
      .state_dbg          (state_dbg)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   typedef struct {
      int st;
      bit plt;
      int lap;
   } exp_t;

   exp_t expQ[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model: phase of the race, frames waited, lap count, recent go levels.
   int       mSt   = 0;
   int       mWait = 0;
   int       mLap  = 0;
   bit       mPlot = 1'b0;
   bit [3:0] goHist = '0;

   // Strobe order: set_reset, start, background, car, over_car, move, explosion.
   function automatic bit [6:0] cmdFor(input int st);
      case (st)
         0:       return 7'b1000000;
         2:       return 7'b0100000;
         3:       return 7'b0010000;
         4:       return 7'b0001000;
         7:       return 7'b0000100;
         8:       return 7'b0000010;
         9:       return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic modelEdge(input bit rn, input bit go, input bit [2:0] keys,
                            input bit [3:0] done, input bit fin, input bit hit);
      int  nxt;
      bit  pulse;
      if (!rn) begin
         mSt = 0; mWait = 0; mLap = 0; mPlot = 1'b0; goHist = '0;
      end else begin
         // A press is seen as a 0->1 step in the level sampled two and three edges back.
         pulse  = goHist[1] & !goHist[2];
         goHist = {goHist[2:0], go};
         mPlot  = (mSt == 3 && !done[3]) || (mSt == 4 && !done[2]) ||
                  (mSt == 7 && !done[1]) || (mSt == 9 && !done[0]);
         if (mSt == 0 || mSt == 2) mLap = 0;
         nxt = mSt;
         case (mSt)
            0:  nxt = 1;
            1:  if (pulse) nxt = 2;
            2:  nxt = 3;
            3:  if (done[3]) nxt = 4;
            4:  if (done[2]) nxt = 5;
            5: begin
               if (hit)      nxt = 9;
               else if (fin) nxt = 10;
               else begin nxt = 6; mWait = 0; end
            end
            6: begin
               if (mWait == FC - 1) begin
                  if (mLap < 65535) mLap++;
                  mWait = 0;
                  if (keys != 3'b000) nxt = 7;
               end else begin
                  mWait++;
               end
            end
            7:  if (done[1]) nxt = 8;
            8:  nxt = 4;
            9:  if (done[0]) nxt = 10;
            10: if (pulse) nxt = 0;
            default: nxt = 0;
         endcase
         mSt = nxt;
      end
      expQ.push_back('{mSt, mPlot, mLap});
   endtask

   task automatic apply(input bit rn, input bit go, input bit [2:0] keys,
                        input bit [3:0] done, input bit fin, input bit hit);
      @(negedge Clock);
      Resetn = rn;
      go_key = go;
      {moveForward, moveRight, moveLeft} = keys;
      {DoneDrawBackground, DoneDrawCar, DoneDrawOverCar, DoneDrawExplosion} = done;
      FinishedRace = fin;
      HitWall      = hit;
      modelEdge(rn, go, keys, done, fin, hit);
   endtask

   task automatic run(input int n, input bit rn, input bit go, input bit [2:0] keys,
                      input bit [3:0] done, input bit fin, input bit hit);
      for (int i = 0; i < n; i++) apply(rn, go, keys, done, fin, hit);
   endtask

   function automatic bit [6:0] dutCmd();
      return {set_reset_signals, start_race, draw_background, draw_car,
              draw_over_car, move, draw_explosion};
   endfunction

   // Monitor: one expected record per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("state_dbg", int'(state_dbg), e.st);
            check("commands", int'(dutCmd()), int'(cmdFor(e.st)));
            check("plot", int'(plot), int'(e.plt));
            check("cmd_onehot", int'($countones(dutCmd()) <= 1), 1);
`ifdef RACE_LAP_TIMER_EN
            check("lap_frames", int'(lap_frames), e.lap);
`endif
         end
      end
   end

   // Reset must act without waiting for a clock edge.
   always @(negedge Resetn) begin
      #1;
      check("async_rst_state", int'(state_dbg), 0);
      check("async_rst_cmd", int'(dutCmd()), 64);
      check("async_rst_plot", int'(plot), 0);
   end

   initial begin
      bit       goLvl;
      bit       rn;
      bit [2:0] keys;
      bit [3:0] done;
      Resetn = 1'b0; go_key = 1'b0;
      moveForward = 1'b0; moveRight = 1'b0; moveLeft = 1'b0;
      DoneDrawBackground = 1'b0; DoneDrawCar = 1'b0;
      DoneDrawOverCar = 1'b0; DoneDrawExplosion = 1'b0;
      FinishedRace = 1'b0; HitWall = 1'b0;

      // Reset, release, start and a slow background draw.
      run(3, 0, 0, 3'b000, 4'b0000, 0, 0);
      run(3, 1, 0, 3'b000, 4'b0000, 0, 0);
      run(2, 1, 1, 3'b000, 4'b0000, 0, 0);
      run(4, 1, 0, 3'b000, 4'b0000, 0, 0);
      run(5, 1, 0, 3'b000, 4'b0000, 0, 0);
      run(1, 1, 0, 3'b000, 4'b1000, 0, 0);
      // Car draw, then a frame with forward held: wait, erase, move, redraw.
      run(2, 1, 0, 3'b100, 4'b0000, 0, 0);
      run(1, 1, 0, 3'b100, 4'b0100, 0, 0);
      run(6, 1, 0, 3'b100, 4'b0000, 0, 0);
      run(1, 1, 0, 3'b000, 4'b0010, 0, 0);
      run(2, 1, 0, 3'b000, 4'b0000, 0, 0);
      // Idle frames: no keys through three full wait periods.
      run(1, 1, 0, 3'b000, 4'b0100, 0, 0);
      run(14, 1, 0, 3'b000, 4'b0000, 0, 0);
      // Steer left into the wall: explode, finish, restart via go.
      run(4, 1, 0, 3'b001, 4'b0000, 0, 0);
      run(1, 1, 0, 3'b000, 4'b0010, 0, 0);
      run(2, 1, 0, 3'b000, 4'b0000, 0, 0);
      run(1, 1, 0, 3'b000, 4'b0100, 0, 1);
      run(3, 1, 0, 3'b000, 4'b0000, 0, 1);
      run(1, 1, 0, 3'b000, 4'b0001, 0, 0);
      run(2, 1, 1, 3'b000, 4'b0000, 0, 0);
      run(6, 1, 0, 3'b000, 4'b0000, 0, 0);
      // Second race, reset asserted during the erase draw.
      run(2, 1, 1, 3'b000, 4'b0000, 0, 0);
      run(5, 1, 0, 3'b000, 4'b0000, 0, 0);
      run(1, 1, 0, 3'b000, 4'b1000, 0, 0);
      run(1, 1, 0, 3'b010, 4'b0100, 0, 0);
      run(7, 1, 0, 3'b010, 4'b0000, 0, 0);
      run(2, 0, 0, 3'b000, 4'b0000, 0, 0);
      run(3, 1, 0, 3'b000, 4'b0000, 0, 0);

      // Randomised play.
      goLvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) goLvl = ~goLvl;
         rn   = ($urandom_range(0, 399) != 0);
         keys = ($urandom_range(0, 4) < 2) ? 3'b000 : 3'($urandom_range(1, 7));
         done = '0;
         for (int b = 0; b < 4; b++) done[b] = ($urandom_range(0, 2) == 0);
         apply(rn, goLvl, keys, done,
               $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
      end
      run(2, 1, 0, 3'b000, 4'b0000, 0, 0);

      repeat (2) @(posedge Clock);
      #2;
      check("scoreboard_drained", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
